// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard controller bundle: ID/EX/MEM hazard sources, memory handshakes,
// stage-register enables/flushes and status.
interface pipe_hazard_ctrl_if;
   localparam int unsigned REG_W = 5;
   localparam int unsigned ST_W  = 3;
   localparam int unsigned CNT_W = 16;

   logic [REG_W-1:0] id_rs_reg;
   logic [REG_W-1:0] id_rt_reg;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic [REG_W-1:0] ex_rd_reg;
   logic             ex_reg_write;
   logic [REG_W-1:0] mem_rd_reg;
   logic             mem_reg_write;
   logic             redirect;
   logic             imem_ready;
   logic             dmem_req;
   logic             dmem_ready;
   logic             halt_req;

   logic             pc_wren;
   logic             fd_wren;
   logic             de_wren;
   logic             em_wren;
   logic             mw_wren;
   logic             fd_flush;
   logic             de_flush;
   logic             em_flush;
   logic             mw_flush;
   logic [ST_W-1:0]  state;
   logic             halted;
   logic             bus_err;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] redirect_count;

   modport master (
      output id_rs_reg, id_rt_reg, id_uses_rs, id_uses_rt,
      output ex_rd_reg, ex_reg_write, mem_rd_reg, mem_reg_write,
      output redirect, imem_ready, dmem_req, dmem_ready, halt_req,
      input  pc_wren, fd_wren, de_wren, em_wren, mw_wren,
      input  fd_flush, de_flush, em_flush, mw_flush,
      input  state, halted, bus_err, stall_cycles, redirect_count
   );

   modport slave (
      input  id_rs_reg, id_rt_reg, id_uses_rs, id_uses_rt,
      input  ex_rd_reg, ex_reg_write, mem_rd_reg, mem_reg_write,
      input  redirect, imem_ready, dmem_req, dmem_ready, halt_req,
      output pc_wren, fd_wren, de_wren, em_wren, mw_wren,
      output fd_flush, de_flush, em_flush, mw_flush,
      output state, halted, bus_err, stall_cycles, redirect_count
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, redirects, data-memory
// waits with timeout, halt draining and stall/redirect statistics.
module pipe_hazard_ctrl (
   input logic               clk,
   input logic               reset_n,
   pipe_hazard_ctrl_if.slave bus
);
   localparam int unsigned REG_W   = 5;
   localparam int unsigned ST_W    = 3;
   localparam int unsigned TMO_W   = 8;
   localparam int unsigned DRAIN_W = 3;
   localparam int unsigned CNT_W   = 16;

   localparam logic [TMO_W-1:0]   TMO_MAX    = {TMO_W{1'b1}};
   localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(4);
   localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

   typedef enum logic [ST_W-1:0] {
      RUN    = 3'd0,
      DWAIT  = 3'd1,
      DRAIN  = 3'd2,
      HALTED = 3'd3,
      ERR    = 3'd4
   } state_t;

   state_t             cur;
   state_t             nxt;
   logic [TMO_W-1:0]   tmo;
   logic [TMO_W-1:0]   tmo_nxt;
   logic [DRAIN_W-1:0] drain_cnt;
   logic [DRAIN_W-1:0] drain_nxt;
   logic [CNT_W-1:0]   stall_cnt;
   logic [CNT_W-1:0]   redir_cnt;

   logic rs_hit, rt_hit, hazard, dmem_stall;
   logic iss_pc, iss_fd, iss_fd_f, iss_de_f;
   logic pc_w, fd_w, de_w, em_w, mw_w;
   logic fd_f, de_f, em_f, mw_f;
   logic redir_inc, stall_inc;

   // Only EX and MEM producers matter; WB writes back before ID reads.
   function automatic logic src_hit(input logic en, input logic [REG_W-1:0] src,
                                    input logic [REG_W-1:0] ex_rd, input logic ex_w,
                                    input logic [REG_W-1:0] mem_rd, input logic mem_w);
      return en && (src != REG_W'(0)) &&
             ((ex_w && (src == ex_rd)) || (mem_w && (src == mem_rd)));
   endfunction

   always_comb begin
      rs_hit     = src_hit(bus.id_uses_rs, bus.id_rs_reg, bus.ex_rd_reg, bus.ex_reg_write,
                           bus.mem_rd_reg, bus.mem_reg_write);
      rt_hit     = src_hit(bus.id_uses_rt, bus.id_rt_reg, bus.ex_rd_reg, bus.ex_reg_write,
                           bus.mem_rd_reg, bus.mem_reg_write);
      hazard     = rs_hit || rt_hit;
      dmem_stall = bus.dmem_req && !bus.dmem_ready;
   end

   // Normal issue: hazard bubble into DE, else fetch bubble into FD, else advance.
   always_comb begin
      iss_pc   = 1'b1;
      iss_fd   = 1'b1;
      iss_fd_f = 1'b0;
      iss_de_f = 1'b0;
      if (hazard) begin
         iss_pc   = 1'b0;
         iss_fd   = 1'b0;
         iss_de_f = 1'b1;
      end else if (!bus.imem_ready) begin
         iss_pc   = 1'b0;
         iss_fd_f = 1'b1;
      end
   end

   // Next state and stage-register controls.
   always_comb begin
      nxt       = cur;
      tmo_nxt   = tmo;
      drain_nxt = drain_cnt;
      redir_inc = 1'b0;
      stall_inc = 1'b0;
      pc_w = 1'b0; fd_w = 1'b0; de_w = 1'b0; em_w = 1'b0; mw_w = 1'b0;
      fd_f = 1'b0; de_f = 1'b0; em_f = 1'b0; mw_f = 1'b0;

      case (cur)
         RUN: begin
            if (dmem_stall) begin
               mw_w    = 1'b1;
               mw_f    = 1'b1;
               tmo_nxt = TMO_W'(1);
               nxt     = DWAIT;
            end else begin
               tmo_nxt = '0;
               if (bus.redirect) begin
                  pc_w = 1'b1; fd_w = 1'b1; de_w = 1'b1; em_w = 1'b1; mw_w = 1'b1;
                  fd_f = 1'b1; de_f = 1'b1; em_f = 1'b1;
                  redir_inc = 1'b1;
               end else begin
                  pc_w = iss_pc; fd_w = iss_fd; de_w = 1'b1; em_w = 1'b1; mw_w = 1'b1;
                  fd_f = iss_fd_f; de_f = iss_de_f;
                  if (bus.halt_req) begin
                     nxt       = DRAIN;
                     drain_nxt = DRAIN_INIT;
                  end
               end
            end
         end

         DWAIT: begin
            if (!bus.dmem_ready) begin
               mw_w    = 1'b1;
               mw_f    = 1'b1;
               tmo_nxt = tmo + TMO_W'(1);
               if (tmo == TMO_MAX) nxt = ERR;
            end else begin
               pc_w = iss_pc; fd_w = iss_fd; de_w = 1'b1; em_w = 1'b1; mw_w = 1'b1;
               fd_f = iss_fd_f; de_f = iss_de_f;
               tmo_nxt = '0;
               nxt     = RUN;
            end
         end

         DRAIN: begin
            if (dmem_stall) begin
               mw_w    = 1'b1;
               mw_f    = 1'b1;
               tmo_nxt = tmo + TMO_W'(1);
               if (tmo == TMO_MAX) nxt = ERR;
            end else begin
               tmo_nxt = '0;
               pc_w = 1'b0; fd_w = 1'b1; de_w = 1'b1; em_w = 1'b1; mw_w = 1'b1;
               if (bus.redirect) begin
                  pc_w = 1'b1;
                  fd_f = 1'b1; de_f = 1'b1; em_f = 1'b1;
                  redir_inc = 1'b1;
                  nxt       = HALTED;
               end else if (hazard) begin
                  fd_w = 1'b0;
                  de_f = 1'b1;
               end else begin
                  // Fetch is shut off; keep retiring until the count runs out.
                  fd_f      = 1'b1;
                  drain_nxt = drain_cnt - DRAIN_W'(1);
                  if (drain_cnt <= DRAIN_W'(1)) nxt = HALTED;
               end
            end
         end

         HALTED: begin
            if (!bus.halt_req) nxt = RUN;
         end

         ERR: begin
            nxt = ERR;
         end

         default: begin
            nxt = RUN;
         end
      endcase

      stall_inc = !pc_w && ((cur == RUN) || (cur == DWAIT) || (cur == DRAIN));

      if (!reset_n) begin
         pc_w = 1'b0; fd_w = 1'b0; de_w = 1'b0; em_w = 1'b0; mw_w = 1'b0;
         fd_f = 1'b0; de_f = 1'b0; em_f = 1'b0; mw_f = 1'b0;
      end
   end

   // State, timeout, drain count and statistics.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cur       <= RUN;
         tmo       <= '0;
         drain_cnt <= '0;
         stall_cnt <= '0;
         redir_cnt <= '0;
      end else begin
         cur       <= nxt;
         tmo       <= tmo_nxt;
         drain_cnt <= drain_nxt;
         if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (redir_inc) redir_cnt <= redir_cnt + CNT_W'(1);
      end
   end

   assign bus.pc_wren        = pc_w;
   assign bus.fd_wren        = fd_w;
   assign bus.de_wren        = de_w;
   assign bus.em_wren        = em_w;
   assign bus.mw_wren        = mw_w;
   assign bus.fd_flush       = fd_f;
   assign bus.de_flush       = de_f;
   assign bus.em_flush       = em_f;
   assign bus.mw_flush       = mw_f;
   assign bus.state          = ST_W'(cur);
   assign bus.halted         = reset_n && (cur == HALTED);
   assign bus.bus_err        = reset_n && (cur == ERR);
   assign bus.stall_cycles   = stall_cnt;
   assign bus.redirect_count = redir_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; a scoreboard queue holds the expected
// response of each driven cycle and a negedge monitor compares it.
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if bus ();

   pipe_hazard_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   typedef struct packed {
      logic       rst_n;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic [4:0] exd;
      logic       exw;
      logic [4:0] memd;
      logic       memw;
      logic       redirect;
      logic       imem_ready;
      logic       dmem_req;
      logic       dmem_ready;
      logic       halt_req;
   } in_t;

   typedef struct packed {
      logic [15:0] id;
      logic [4:0]  wren;
      logic [3:0]  flush;
      logic [2:0]  st;
      logic        halted;
      logic        bus_err;
      logic [15:0] sc;
      logic [15:0] rc;
   } exp_t;

   localparam logic [2:0] S_RUN = 3'd0, S_DWAIT = 3'd1, S_DRAIN = 3'd2,
                          S_HALTED = 3'd3, S_ERR = 3'd4;
   // wren = {pc,fd,de,em,mw}; flush = {fd,de,em,mw}
   localparam logic [4:0] W_ALL = 5'b11111, W_NONE = 5'b00000, W_MW = 5'b00001,
                          W_HAZ = 5'b00111, W_NOPC = 5'b01111;
   localparam logic [3:0] F_NONE = 4'b0000, F_MW = 4'b0001, F_RED = 4'b1110,
                          F_DE = 4'b0100, F_FD = 4'b1000;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   vec_id = 0;
   in_t  iv;

   function automatic in_t idle();
      in_t i;
      i            = '0;
      i.rst_n      = 1'b1;
      i.imem_ready = 1'b1;
      i.dmem_ready = 1'b1;
      return i;
   endfunction

   task automatic apply(input in_t i);
      reset_n           = i.rst_n;
      bus.id_rs_reg     = i.rs;
      bus.id_rt_reg     = i.rt;
      bus.id_uses_rs    = i.urs;
      bus.id_uses_rt    = i.urt;
      bus.ex_rd_reg     = i.exd;
      bus.ex_reg_write  = i.exw;
      bus.mem_rd_reg    = i.memd;
      bus.mem_reg_write = i.memw;
      bus.redirect      = i.redirect;
      bus.imem_ready    = i.imem_ready;
      bus.dmem_req      = i.dmem_req;
      bus.dmem_ready    = i.dmem_ready;
      bus.halt_req      = i.halt_req;
   endtask

   // Drive one cycle of inputs and queue the response expected during that cycle.
   task automatic v(input in_t i, input logic [4:0] w, input logic [3:0] f,
                    input logic [2:0] st, input logic h, input logic be,
                    input int sc, input int rc);
      exp_t e;
      @(posedge clk);
      #1;
      apply(i);
      e.id      = 16'(vec_id);
      e.wren    = w;
      e.flush   = f;
      e.st      = st;
      e.halted  = h;
      e.bus_err = be;
      e.sc      = 16'(sc);
      e.rc      = 16'(rc);
      q.push_back(e);
      vec_id++;
   endtask

   task automatic chk(input string name, input logic [15:0] id,
                      input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, id, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("wren",  e.id, 16'({bus.pc_wren, bus.fd_wren, bus.de_wren, bus.em_wren, bus.mw_wren}),
             16'(e.wren));
         chk("flush", e.id, 16'({bus.fd_flush, bus.de_flush, bus.em_flush, bus.mw_flush}),
             16'(e.flush));
         chk("state",          e.id, 16'(bus.state),   16'(e.st));
         chk("halted",         e.id, 16'(bus.halted),  16'(e.halted));
         chk("bus_err",        e.id, 16'(bus.bus_err), 16'(e.bus_err));
         chk("stall_cycles",   e.id, bus.stall_cycles,   e.sc);
         chk("redirect_count", e.id, bus.redirect_count, e.rc);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, vec %0d", vec_id);
      $fatal(1, "watchdog");
   end

   initial begin
      iv = idle(); iv.rst_n = 1'b0;
      apply(iv);

      // Reset masks every control even with hazard/halt inputs present.
      iv = idle(); iv.rst_n = 1'b0; iv.halt_req = 1'b1; iv.urs = 1'b1; iv.rs = 5'd5;
      iv.exd = 5'd5; iv.exw = 1'b1;
      v(iv, W_NONE, F_NONE, S_RUN, 0, 0, 0, 0);
      v(iv, W_NONE, F_NONE, S_RUN, 0, 0, 0, 0);

      // Load-use: producer in EX, then MEM, then gone.
      iv = idle(); iv.urs = 1'b1; iv.rs = 5'd5; iv.exd = 5'd5; iv.exw = 1'b1;
      v(iv, W_HAZ, F_DE, S_RUN, 0, 0, 0, 0);
      iv = idle(); iv.urs = 1'b1; iv.rs = 5'd5; iv.memd = 5'd5; iv.memw = 1'b1;
      v(iv, W_HAZ, F_DE, S_RUN, 0, 0, 1, 0);
      iv = idle(); iv.urs = 1'b1; iv.rs = 5'd5;
      v(iv, W_ALL, F_NONE, S_RUN, 0, 0, 2, 0);
      // r0 never hazards; unused source never hazards; rt via MEM does.
      iv = idle(); iv.urt = 1'b1; iv.rt = 5'd0; iv.exd = 5'd0; iv.exw = 1'b1;
      v(iv, W_ALL, F_NONE, S_RUN, 0, 0, 2, 0);
      iv = idle(); iv.rt = 5'd7; iv.exd = 5'd7; iv.exw = 1'b1;
      v(iv, W_ALL, F_NONE, S_RUN, 0, 0, 2, 0);
      iv = idle(); iv.urt = 1'b1; iv.rt = 5'd7; iv.exd = 5'd7; iv.memd = 5'd7; iv.memw = 1'b1;
      v(iv, W_HAZ, F_DE, S_RUN, 0, 0, 2, 0);
      iv = idle(); iv.imem_ready = 1'b0;
      v(iv, W_NOPC, F_FD, S_RUN, 0, 0, 3, 0);
      iv = idle();
      v(iv, W_ALL, F_NONE, S_RUN, 0, 0, 4, 0);

      // Redirect beats hazard and fetch miss.
      iv = idle(); iv.redirect = 1'b1; iv.urs = 1'b1; iv.rs = 5'd5; iv.exd = 5'd5;
      iv.exw = 1'b1; iv.imem_ready = 1'b0;
      v(iv, W_ALL, F_RED, S_RUN, 0, 0, 4, 0);
      iv = idle();
      v(iv, W_ALL, F_NONE, S_RUN, 0, 0, 4, 1);

      // Data-memory wait beats redirect; ready cycle issues normally, halt deferred.
      iv = idle(); iv.dmem_req = 1'b1; iv.dmem_ready = 1'b0; iv.redirect = 1'b1;
      v(iv, W_MW, F_MW, S_RUN, 0, 0, 4, 1);
      iv = idle(); iv.dmem_req = 1'b1; iv.dmem_ready = 1'b0;
      v(iv, W_MW, F_MW, S_DWAIT, 0, 0, 5, 1);
      v(iv, W_MW, F_MW, S_DWAIT, 0, 0, 6, 1);
      iv = idle(); iv.dmem_req = 1'b1; iv.halt_req = 1'b1;
      v(iv, W_ALL, F_NONE, S_DWAIT, 0, 0, 7, 1);
      iv = idle(); iv.halt_req = 1'b1;
      v(iv, W_ALL, F_NONE, S_RUN, 0, 0, 7, 1);

      // Drain four cycles, then halted until halt_req drops.
      for (int k = 0; k < 4; k++) begin
         iv = idle(); iv.halt_req = 1'b1;
         v(iv, W_NOPC, F_FD, S_DRAIN, 0, 0, 7 + k, 1);
      end
      iv = idle(); iv.halt_req = 1'b1;
      v(iv, W_NONE, F_NONE, S_HALTED, 1, 0, 11, 1);
      iv = idle();
      v(iv, W_NONE, F_NONE, S_HALTED, 1, 0, 11, 1);
      v(iv, W_ALL, F_NONE, S_RUN, 0, 0, 11, 1);

      // Hazard pauses the drain count; reset mid-drain clears everything.
      iv = idle(); iv.halt_req = 1'b1;
      v(iv, W_ALL, F_NONE, S_RUN, 0, 0, 11, 1);
      iv = idle(); iv.urs = 1'b1; iv.rs = 5'd5; iv.exd = 5'd5; iv.exw = 1'b1;
      v(iv, W_HAZ, F_DE, S_DRAIN, 0, 0, 11, 1);
      iv = idle();
      v(iv, W_NOPC, F_FD, S_DRAIN, 0, 0, 12, 1);
      v(iv, W_NOPC, F_FD, S_DRAIN, 0, 0, 13, 1);
      iv = idle(); iv.rst_n = 1'b0;
      v(iv, W_NONE, F_NONE, S_DRAIN, 0, 0, 14, 1);
      iv = idle();
      v(iv, W_ALL, F_NONE, S_RUN, 0, 0, 0, 0);
      v(iv, W_ALL, F_NONE, S_RUN, 0, 0, 0, 0);

      // Redirect during drain goes straight to HALTED.
      iv = idle(); iv.halt_req = 1'b1;
      v(iv, W_ALL, F_NONE, S_RUN, 0, 0, 0, 0);
      iv.redirect = 1'b1;
      v(iv, W_ALL, F_RED, S_DRAIN, 0, 0, 0, 0);
      iv = idle();
      v(iv, W_NONE, F_NONE, S_HALTED, 1, 0, 0, 1);

      // Data-memory wait inside drain holds the drain.
      iv = idle(); iv.halt_req = 1'b1;
      v(iv, W_ALL, F_NONE, S_RUN, 0, 0, 0, 1);
      iv = idle(); iv.dmem_req = 1'b1; iv.dmem_ready = 1'b0;
      v(iv, W_MW, F_MW, S_DRAIN, 0, 0, 0, 1);
      iv = idle(); iv.dmem_req = 1'b1;
      v(iv, W_NOPC, F_FD, S_DRAIN, 0, 0, 1, 1);
      iv = idle(); iv.rst_n = 1'b0;
      v(iv, W_NONE, F_NONE, S_DRAIN, 0, 0, 2, 1);

      // Timeout: 1 RUN cycle + tmo 1..255 in DWAIT, then ERR until reset.
      iv = idle(); iv.dmem_req = 1'b1; iv.dmem_ready = 1'b0;
      v(iv, W_MW, F_MW, S_RUN, 0, 0, 0, 0);
      for (int k = 1; k <= 255; k++) v(iv, W_MW, F_MW, S_DWAIT, 0, 0, k, 0);
      for (int k = 0; k < 44; k++) begin
         if (k == 43) begin
            iv.dmem_ready = 1'b1; iv.redirect = 1'b1; iv.halt_req = 1'b1;
         end
         v(iv, W_NONE, F_NONE, S_ERR, 0, 1, 256, 0);
      end
      iv = idle(); iv.rst_n = 1'b0;
      v(iv, W_NONE, F_NONE, S_ERR, 0, 0, 256, 0);
      iv = idle();
      v(iv, W_ALL, F_NONE, S_RUN, 0, 0, 0, 0);

      // DWAIT ready cycle uses hazard priority and ignores redirect.
      iv = idle(); iv.dmem_req = 1'b1; iv.dmem_ready = 1'b0;
      v(iv, W_MW, F_MW, S_RUN, 0, 0, 0, 0);
      iv = idle(); iv.dmem_req = 1'b1; iv.redirect = 1'b1; iv.urs = 1'b1; iv.rs = 5'd5;
      iv.memd = 5'd5; iv.memw = 1'b1;
      v(iv, W_HAZ, F_DE, S_DWAIT, 0, 0, 1, 0);
      iv = idle();
      v(iv, W_ALL, F_NONE, S_RUN, 0, 0, 2, 0);

      repeat (3) @(negedge clk);
      #1;
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have these ports: clk  in  1  clock; all state changes on posedge.
REQ-002 SHALL have these ports: reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have these ports: id_rs_reg, id_rt_reg  in  5 each  ID-stage source registers; id_uses_rs, id_uses_rt  in  1 each  source-valid flags.
REQ-004 SHALL have these ports: ex_rd_reg  in  5; ex_reg_write  in  1  (DE-register outputs).
REQ-005 SHALL have these ports: mem_rd_reg  in  5; mem_reg_write  in  1  (EM-register outputs).
REQ-006 SHALL have these ports: redirect  in  1  branch taken or jump resolved in MEM; the PC mux selects the target.
REQ-007 SHALL have these ports: imem_ready  in  1; dmem_req  in  1  (MEM-stage load/store); dmem_ready  in  1; halt_req  in  1.
REQ-008 SHALL have these ports: pc_wren, fd_wren, de_wren, em_wren, mw_wren  out  1 each  stage-register write enables.
REQ-009 SHALL have these ports: fd_flush, de_flush, em_flush, mw_flush  out  1 each; flush=1 together with wren=1 loads a bubble (all controls 0).
REQ-010 SHALL have these ports: state  out  3; halted  out  1; bus_err  out  1; stall_cycles  out  16; redirect_count  out  16.

Function
REQ-011 SHALL use state encoding RUN=0, DWAIT=1, DRAIN=2, HALTED=3, ERR=4; the state output SHALL equal the registered state.
REQ-012 SHALL generate enables and flushes combinationally from the current state and inputs; state and counters SHALL be registered.
REQ-013 SHALL define hazard = (id_uses_rs, rs!=0, rs matches ex_rd with ex_reg_write or mem_rd with mem_reg_write) OR the same for rt; WB-stage producers are not checked.
REQ-014 RUN, priority 1: if dmem_req and !dmem_ready, SHALL drive all wren=0 except mw_wren=1 with mw_flush=1, set tmo=1, and go to DWAIT.
REQ-015 RUN, priority 2: if redirect, SHALL drive all wren=1 and fd/de/em_flush=1, and increment redirect_count (wrapping).
REQ-016 RUN, priority 3: if hazard, SHALL drive pc_wren=0 and fd_wren=0, de_wren=1 with de_flush=1, and em/mw_wren=1.
REQ-017 RUN, priority 4: if !imem_ready, SHALL drive pc_wren=0, fd_wren=1 with fd_flush=1, and all other wren=1.
REQ-018 RUN, priority 5 (none of the above): SHALL drive all wren=1 and all flush=0.
REQ-019 RUN: if halt_req=1 in a cycle without priority 1 or 2, SHALL go to DRAIN with drain_cnt=4.
REQ-020 DWAIT: while !dmem_ready, SHALL freeze as in REQ-014 and increment tmo (8-bit); if tmo==255 and !dmem_ready, SHALL go to ERR.
REQ-021 DWAIT: on dmem_ready, SHALL evaluate that cycle with RUN priorities 3-5 and go to RUN; a pending halt_req is taken next cycle in RUN.
REQ-022 DRAIN: SHALL apply REQ-014 (staying in DRAIN, using tmo/ERR as in REQ-020) and REQ-016 unchanged.
REQ-023 DRAIN: otherwise SHALL drive pc_wren=0, fd_flush=1, all wren=1, and decrement drain_cnt; when drain_cnt==1 and decrementing, SHALL go to HALTED.
REQ-024 DRAIN: on redirect, SHALL act as REQ-015 and go directly to HALTED.
REQ-025 HALTED: SHALL drive all wren=0, all flush=0, halted=1; on halt_req=0, SHALL go to RUN.
REQ-026 ERR: SHALL drive all wren=0, bus_err=1, and stay in ERR until reset.
REQ-027 stall_cycles SHALL increment, saturating at 0xFFFF, in every RUN/DWAIT/DRAIN cycle with pc_wren=0.

Reset
REQ-028 While reset_n=0 at posedge: state<=RUN, tmo<=0, drain_cnt<=0, stall_cycles<=0, redirect_count<=0.
REQ-029 While reset_n=0: all wren=0, all flush=0, halted=0, bus_err=0, regardless of state.
REQ-030 Reset asserted in any state, including mid-DWAIT or in ERR, SHALL return to RUN on the first posedge.

Verification
REQ-031 Load to r5 in EX, ID reads rs=5 -> 1 cycle pc/fd_wren=0, de_flush=1; 2nd cycle (r5 in MEM) same; 3rd cycle all wren=1; stall_cycles=2.
REQ-032 redirect=1 with hazard and !imem_ready also present -> pc_wren=1, fd/de/em_flush=1, no stall; redirect_count 0->1.
REQ-033 dmem_req=1, dmem_ready low 3 cycles then high -> state DWAIT for 3 cycles with mw_flush=1; ready cycle all wren=1; back to RUN.
REQ-034 dmem_ready held low 300 cycles -> ERR entered after tmo reaches 255; bus_err=1 held; reset_n=0 one cycle -> RUN, bus_err=0.
REQ-035 halt_req=1 in RUN -> DRAIN for exactly 4 cycles with fd_flush=1, then HALTED, halted=1; halt_req=0 -> RUN next cycle.
REQ-036 Reset during DRAIN with drain_cnt=2 -> RUN, all counters 0, halt re-entered only on a fresh halt_req sample.
